// File: rtl/raw_hazard_unit.sv
// Read-after-write hazard detector between ID and EX: tracks destination registers of
// in-flight instructions and stalls ID (inserting an EX bubble) while a source is pending.
module raw_hazard_unit #(
    parameter int DEPTH     = 3,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             stall_ext,
    input  logic             flush,
    output logic             issue,
    output logic             stall,
    output logic             hazard_rs,
    output logic             hazard_rt,
    output logic [CNT_W-1:0] stall_count
);

    // The write-back slot is covered by the register file forwarding when RF_BYPASS is set.
    localparam int NCHK = RF_BYPASS ? (DEPTH - 1) : DEPTH;

    logic [DEPTH-1:0] slot_v_r;
    logic [2:0]       slot_rd_r [DEPTH];
    logic [CNT_W-1:0] stall_count_r;

    logic match_rs_s;
    logic match_rt_s;
    logic hazard_s;
    logic issue_s;

    function automatic logic slot_match(input logic v, input logic [2:0] rd, input logic [2:0] x);
        return v && (rd == x);
    endfunction

    // Compare both sources against every checked valid slot.
    always_comb begin
        match_rs_s = 1'b0;
        match_rt_s = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            match_rs_s = match_rs_s | ((s < NCHK) && slot_match(slot_v_r[s], slot_rd_r[s], id_rs));
            match_rt_s = match_rt_s | ((s < NCHK) && slot_match(slot_v_r[s], slot_rd_r[s], id_rt));
        end
    end

    // Hazard, stall and issue decisions are combinational so ID sees them in the same cycle.
    always_comb begin
        hazard_rs = id_valid & id_rs_used & match_rs_s;
        hazard_rt = id_valid & id_rt_used & match_rt_s;
        hazard_s  = hazard_rs | hazard_rt;
        stall     = (hazard_s | stall_ext) & ~flush;
        issue_s   = id_valid & ~hazard_s & ~stall_ext & ~flush;
        issue     = issue_s;
    end

    // Scoreboard shift: flush advances once with a cleared slot0, stall_ext freezes the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v_r <= {DEPTH{1'b0}};
            for (int s = 0; s < DEPTH; s++) begin
                slot_rd_r[s] <= 3'b000;
            end
        end else if (flush) begin
            for (int s = 1; s < DEPTH; s++) begin
                slot_v_r[s]  <= slot_v_r[s-1];
                slot_rd_r[s] <= slot_rd_r[s-1];
            end
            slot_v_r[0]  <= 1'b0;
            slot_rd_r[0] <= 3'b000;
        end else if (!stall_ext) begin
            for (int s = 1; s < DEPTH; s++) begin
                slot_v_r[s]  <= slot_v_r[s-1];
                slot_rd_r[s] <= slot_rd_r[s-1];
            end
            slot_v_r[0]  <= issue_s & id_wr_en;
            slot_rd_r[0] <= issue_s ? id_rd : 3'b000;
        end
    end

    // Saturating count of cycles lost to RAW hazards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (hazard_s && !stall_ext && !flush && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_raw_hazard_unit.sv
// Scoreboard bench for raw_hazard_unit: three builds (default, no bypass, 4-bit counter)
// share one stimulus stream and are checked against a queue-based pipeline model.
module tb_raw_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_wr_en, stall_ext, flush;
    logic [2:0] id_rs, id_rt, id_rd;

    logic iss [3];
    logic stl [3];
    logic hrs [3];
    logic hrt [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic v; logic [2:0] rd; } ent_t;
    typedef struct { int k; bit iss; bit stl; bit hrs; bit hrt; int cnt; } exp_t;

    ent_t pipe [3][$];
    int   mcnt [3];
    int   chk_n [3] = '{2, 3, 2};
    int   cmax [3]  = '{65535, 65535, 15};
    exp_t expq [$];

    always #5 clk = ~clk;

    raw_hazard_unit u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .stall_ext(stall_ext), .flush(flush), .issue(iss[0]), .stall(stl[0]),
        .hazard_rs(hrs[0]), .hazard_rt(hrt[0]), .stall_count(cnt0));

    raw_hazard_unit #(.DEPTH(3), .RF_BYPASS(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .stall_ext(stall_ext), .flush(flush), .issue(iss[1]), .stall(stl[1]),
        .hazard_rs(hrs[1]), .hazard_rt(hrt[1]), .stall_count(cnt1));

    raw_hazard_unit #(.DEPTH(3), .RF_BYPASS(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .stall_ext(stall_ext), .flush(flush), .issue(iss[2]), .stall(stl[2]),
        .hazard_rs(hrs[2]), .hazard_rt(hrt[2]), .stall_count(cnt2));

    function automatic int get_cnt(input int k);
        if (k == 0) return int'(cnt0);
        else if (k == 1) return int'(cnt1);
        else return int'(cnt2);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pipe[k].delete();
            repeat (3) pipe[k].push_back(ent_t'(4'b0000));
            mcnt[k] = 0;
        end
    endtask

    // One ID cycle: drive inputs, predict every build's outputs, then advance the model.
    task automatic cyc(input bit v, input logic [2:0] rs, input bit rsu, input logic [2:0] rt,
                       input bit rtu, input logic [2:0] rd, input bit we, input bit ext, input bit fl);
        bit hr, ht, hz, is, st;
        exp_t e;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_wr_en = we; stall_ext = ext; flush = fl;
        for (int k = 0; k < 3; k++) begin
            hr = 1'b0;
            ht = 1'b0;
            for (int i = 0; i < chk_n[k]; i++) begin
                if (pipe[k][i].v && pipe[k][i].rd == rs) hr = 1'b1;
                if (pipe[k][i].v && pipe[k][i].rd == rt) ht = 1'b1;
            end
            hr = hr && v && rsu;
            ht = ht && v && rtu;
            hz = hr || ht;
            is = v && !hz && !ext && !fl;
            st = (hz || ext) && !fl;
            e.k = k; e.iss = is; e.stl = st; e.hrs = hr; e.hrt = ht; e.cnt = mcnt[k];
            expq.push_back(e);
            if (hz && !ext && !fl && mcnt[k] < cmax[k]) mcnt[k]++;
            if (fl) begin
                pipe[k].push_front(ent_t'(4'b0000));
                void'(pipe[k].pop_back());
            end else if (!ext) begin
                pipe[k].push_front(is ? ent_t'({we, rd}) : ent_t'(4'b0000));
                void'(pipe[k].pop_back());
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic prod(input logic [2:0] rd, input bit we);
        cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, rd, we, 1'b0, 1'b0);
    endtask

    task automatic cons_rs(input logic [2:0] rs, input bit rsu, input bit ext, input bit fl);
        cyc(1'b1, rs, rsu, 3'd0, 1'b0, 3'd0, 1'b0, ext, fl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pops the predictions for the current cycle and compares the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                chk($sformatf("issue[%0d]", e.k), int'(iss[e.k]), int'(e.iss));
                chk($sformatf("stall[%0d]", e.k), int'(stl[e.k]), int'(e.stl));
                chk($sformatf("hazard_rs[%0d]", e.k), int'(hrs[e.k]), int'(e.hrs));
                chk($sformatf("hazard_rt[%0d]", e.k), int'(hrt[e.k]), int'(e.hrt));
                chk($sformatf("stall_count[%0d]", e.k), get_cnt(e.k), e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1; id_rt = 3'd0; id_rt_used = 1'b0;
        id_rd = 3'd0; id_wr_en = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_issue", int'(iss[k]), 1);
            chk("reset_stall", int'(stl[k]), 0);
            chk("reset_count", get_cnt(k), 0);
        end
        @(negedge clk);
        #1 rst = 1'b0;

        // back-to-back dependency through rs
        prod(3'd5, 1'b1);
        repeat (4) cons_rs(3'd5, 1'b1, 1'b0, 1'b0);
        idle();
        #3;
        chk("b2b_count_bypass", int'(cnt0), 2);
        chk("b2b_count_nobypass", int'(cnt1), 3);

        // dependency through rt only
        do_reset();
        prod(3'd7, 1'b1);
        cyc(1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rt_only_hazard_rt", int'(hrt[1]), 1);
        chk("rt_only_hazard_rs", int'(hrs[1]), 0);
        repeat (3) cyc(1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

        // no false hazards
        do_reset();
        prod(3'd2, 1'b0);
        cons_rs(3'd2, 1'b1, 1'b0, 1'b0);
        #3 chk("no_wr_en_issue", int'(iss[1]), 1);
        prod(3'd2, 1'b1);
        cons_rs(3'd2, 1'b0, 1'b0, 1'b0);
        #3 chk("rs_unused_issue", int'(iss[0]), 1);
        prod(3'd6, 1'b1);
        cons_rs(3'd7, 1'b1, 1'b0, 1'b0);
        #3 chk("one_bit_mismatch_issue", int'(iss[1]), 1);
        prod(3'd0, 1'b1);
        cons_rs(3'd0, 1'b1, 1'b0, 1'b0);
        #3 chk("r0_hazard_stall", int'(stl[0]), 1);

        // external stall while producer sits in slot0
        do_reset();
        prod(3'd1, 1'b1);
        repeat (4) cons_rs(3'd1, 1'b1, 1'b1, 1'b0);
        #3 chk("ext_count_frozen", int'(cnt0), 0);
        repeat (3) cons_rs(3'd1, 1'b1, 1'b0, 1'b0);
        #3 chk("ext_then_resolve", int'(cnt0), 2);

        // flush while the dependent instruction is stalled
        do_reset();
        prod(3'd3, 1'b1);
        cons_rs(3'd3, 1'b1, 1'b0, 1'b0);
        cons_rs(3'd3, 1'b1, 1'b1, 1'b1);
        #3;
        chk("flush_issue", int'(iss[0]), 0);
        chk("flush_stall", int'(stl[0]), 0);
        repeat (3) cons_rs(3'd3, 1'b1, 1'b0, 1'b0);

        // counter saturation on the 4-bit build
        do_reset();
        repeat (12) begin
            prod(3'd4, 1'b1);
            repeat (2) cons_rs(3'd4, 1'b1, 1'b0, 1'b0);
        end
        idle();
        #3;
        chk("sat_count_4bit", int'(cnt2), 15);
        chk("sat_count_16bit", int'(cnt0), 24);

        // asynchronous reset in the middle of a stall
        do_reset();
        prod(3'd6, 1'b1);
        repeat (2) cons_rs(3'd6, 1'b1, 1'b0, 1'b0);
        #3;
        chk("pre_rst_stall", int'(stl[0]), 1);
        chk("pre_rst_count", int'(cnt0), 1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_stall", int'(stl[k]), 0);
            chk("async_rst_count", get_cnt(k), 0);
        end
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        cons_rs(3'd6, 1'b1, 1'b0, 1'b0);
        #3 chk("post_rst_issue", int'(iss[1]), 1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end
        idle();
        @(negedge clk);
        #4;
        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
